// File: rtl/ring_osc_freq_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter: default widths
// and the measurement FSM state encoding.
package ring_osc_freq_meter_pkg;

  localparam int unsigned DEF_GATE_W      = 16;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_rise_detect.sv
// Brings an asynchronous signal into the clk domain and flags its rising edges.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   async_in   asynchronous input
//   rise_c     one-cycle pulse per synchronised rising edge (combinational)
module sync_rise_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain followed by a single history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Counts rising edges of osc_in over a window of gate_len clk cycles and
// presents the count with a valid/ack handshake.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   osc_in        asynchronous oscillator signal to measure
//   start         one-cycle measurement request (gate_len sampled with it)
//   gate_len      window length in clk cycles
//   busy          high while the window is open
//   result        edge count of the last completed window
//   overflow      count saturated during the last window
//   result_valid  result/overflow valid until result_ack or a new start
//   result_ack    consumer acknowledge
module ring_osc_freq_meter
  import ring_osc_freq_meter_pkg::*;
#(
  parameter int unsigned GATE_W      = DEF_GATE_W,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic              overflow,
  output logic              result_valid,
  input  logic              result_ack
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e              state_q, state_nxt;
  logic [GATE_W-1:0]   timer_q, timer_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt, cnt_inc;
  logic                sat_q, sat_nxt, sat_inc;
  logic [CNT_W-1:0]    result_nxt;
  logic                overflow_nxt;
  logic                valid_nxt;
  logic                busy_nxt;
  logic                rise_c;

  sync_rise_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_rise_detect (
    .clk      (clk),
    .rst      (rst),
    .async_in (osc_in),
    .rise_c   (rise_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      cnt_q        <= '0;
      sat_q        <= 1'b0;
      result       <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      timer_q      <= timer_nxt;
      cnt_q        <= cnt_nxt;
      sat_q        <= sat_nxt;
      result       <= result_nxt;
      overflow     <= overflow_nxt;
      result_valid <= valid_nxt;
      busy         <= busy_nxt;
    end
  end

  // Next-state, window timer, saturating counter and result capture.
  always_comb begin
    state_nxt    = state_q;
    timer_nxt    = timer_q;
    cnt_nxt      = cnt_q;
    sat_nxt      = sat_q;
    result_nxt   = result;
    overflow_nxt = overflow;
    valid_nxt    = result_valid;
    cnt_inc      = cnt_q;
    sat_inc      = sat_q;

    // Counter value including this cycle's edge; sticks at max and flags it.
    if (rise_c) begin
      if (cnt_q == CNT_MAX) begin
        sat_inc = 1'b1;
      end else begin
        cnt_inc = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE, HOLD: begin
        // start takes priority over result_ack when both arrive in HOLD.
        if (start) begin
          if (gate_len != '0) begin
            state_nxt = COUNT;
            timer_nxt = gate_len;
            cnt_nxt   = '0;
            sat_nxt   = 1'b0;
            valid_nxt = 1'b0;
          end else begin
            state_nxt    = HOLD;
            result_nxt   = '0;
            overflow_nxt = 1'b0;
            valid_nxt    = 1'b1;
          end
        end else if (state_q == HOLD && result_ack) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      COUNT: begin
        cnt_nxt   = cnt_inc;
        sat_nxt   = sat_inc;
        timer_nxt = timer_q - GATE_W'(1);
        // Last window cycle: its edge is folded straight into the result.
        if (timer_q == GATE_W'(1)) begin
          state_nxt    = HOLD;
          result_nxt   = cnt_inc;
          overflow_nxt = sat_inc;
          valid_nxt    = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == COUNT);
  end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Randomised bench for ring_osc_freq_meter: two instances (full and 4-bit
// counter) share stimulus; expected counts come from a log of osc_in rises.
module tb_ring_osc_freq_meter;

  localparam int unsigned GATE_W  = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_W_S = 4;
  localparam int          MAX_S   = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              osc_in = 1'b0;
  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic              result_ack;

  logic               busy, overflow, result_valid;
  logic [CNT_W-1:0]   result;
  logic               busy_s, overflow_s, valid_s;
  logic [CNT_W_S-1:0] result_s;

  int cyc = 0;
  int osc_period = 0;
  int ph = 0;
  logic osc_prev = 1'b0;
  int rises[$];

  int n_checks = 0;
  int n_errors = 0;

  ring_osc_freq_meter #(.GATE_W(GATE_W), .CNT_W(CNT_W), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .gate_len(gate_len),
    .busy(busy), .result(result), .overflow(overflow),
    .result_valid(result_valid), .result_ack(result_ack)
  );

  ring_osc_freq_meter #(.GATE_W(GATE_W), .CNT_W(CNT_W_S), .SYNC_STAGES(2)) u_dut_s (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .gate_len(gate_len),
    .busy(busy_s), .result(result_s), .overflow(overflow_s),
    .result_valid(valid_s), .result_ack(result_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator: changes 1 ns after a clk edge; every rise is logged by cycle.
  always @(posedge clk) begin
    #1;
    if (osc_period == 0) begin
      osc_in = 1'b0;
    end else begin
      ph = (ph + 1) % osc_period;
      osc_in = (ph < osc_period / 2);
    end
    if (osc_in && !osc_prev) rises.push_back(cyc);
    osc_prev = osc_in;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A rise logged at cycle N reaches the counter on edge N+3; the window
  // opened by a start driven at cycle m counts edges m+2 .. m+1+gl.
  function automatic int model_count(input int m, input int gl);
    int n = 0;
    foreach (rises[i]) begin
      if (rises[i] >= m - 1 && rises[i] <= m + gl - 2) n++;
    end
    return n;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input int gl, input bit with_ack, output int m);
    @(posedge clk); #1;
    start      = 1'b1;
    gate_len   = GATE_W'(gl);
    result_ack = with_ack;
    m          = cyc;
    @(posedge clk); #1;
    start      = 1'b0;
    result_ack = 1'b0;
  endtask

  task automatic finish_window(input string tag, input int gl, input int m,
                               input bit mid_start, output int n);
    int  busy_n = 0;
    int  busy_s_n = 0;
    bit  done = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (busy)   busy_n++;
      if (busy_s) busy_s_n++;
      if (result_valid) begin
        done = 1'b1;
        break;
      end
      start      = 1'b0;
      result_ack = 1'b0;
      if (mid_start && gl >= 4 && k == gl / 2) begin
        start      = 1'b1;
        gate_len   = GATE_W'(gl + 7);
        result_ack = 1'b1;
      end
      @(posedge clk); #1;
    end
    start      = 1'b0;
    result_ack = 1'b0;
    n = model_count(m, gl);
    check({tag, ":done"}, done, 1);
    check({tag, ":latency"}, cyc, m + 1 + gl);
    check({tag, ":busy_cycles"}, busy_n, gl);
    check({tag, ":busy_cycles_s"}, busy_s_n, gl);
    check({tag, ":valid_s"}, valid_s, 1);
    check({tag, ":result"}, result, n);
    check({tag, ":overflow"}, overflow, 0);
    check({tag, ":result_s"}, result_s, (n > MAX_S) ? MAX_S : n);
    check({tag, ":overflow_s"}, overflow_s, (n > MAX_S) ? 1 : 0);
  endtask

  task automatic ack_check(input string tag, input int n);
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
    check({tag, ":valid_cleared"}, result_valid, 0);
    check({tag, ":result_kept"}, result, n);
    check({tag, ":busy_idle"}, busy, 0);
  endtask

  initial begin
    int m, n, gl;
    rst        = 1'b1;
    start      = 1'b0;
    result_ack = 1'b0;
    gate_len   = '0;
    idle(3);
    check("rst:busy", busy, 0);
    check("rst:result", result, 0);
    check("rst:overflow", overflow, 0);
    check("rst:valid", result_valid, 0);
    check("rst:result_s", result_s, 0);
    check("rst:valid_s", valid_s, 0);
    rst = 1'b0;
    idle(4);

    // Period 8 over 800 cycles: about 100 edges.
    osc_period = 8;
    idle(10);
    launch(800, 1'b0, m);
    finish_window("t1", 800, m, 1'b0, n);
    ack_check("t1_ack", n);

    // Quiet oscillator.
    osc_period = 0;
    idle(10);
    launch(50, 1'b0, m);
    finish_window("t2", 50, m, 1'b0, n);
    ack_check("t2_ack", n);

    // Fast enough to saturate the 4-bit instance.
    osc_period = 4;
    idle(5);
    launch(200, 1'b0, m);
    finish_window("t3", 200, m, 1'b0, n);

    // Start together with ack while in HOLD: new window wins.
    launch(60, 1'b1, m);
    check("t5b:valid_drop", result_valid, 0);
    check("t5b:busy", busy, 1);
    finish_window("t5b", 60, m, 1'b0, n);
    ack_check("t5b_ack", n);

    // Zero-length window.
    idle(3);
    launch(0, 1'b0, m);
    finish_window("t4", 0, m, 1'b0, n);
    ack_check("t4_ack", n);

    // start and result_ack during COUNT are ignored.
    osc_period = 5;
    idle(4);
    launch(120, 1'b0, m);
    finish_window("t5a", 120, m, 1'b1, n);

    // Reset mid-window aborts without a result.
    ack_check("t5a_ack", n);
    launch(100, 1'b0, m);
    idle(30);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6:busy", busy, 0);
    check("t6:result", result, 0);
    check("t6:valid", result_valid, 0);
    check("t6:overflow", overflow, 0);
    check("t6:busy_s", busy_s, 0);
    rst = 1'b0;
    idle(8);
    launch(90, 1'b0, m);
    finish_window("t6_after", 90, m, 1'b0, n);

    // Random windows, periods and handshake choices.
    for (int i = 0; i < 20; i++) begin
      osc_period = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(3, 16));
      gl = int'($urandom_range(0, 300));
      idle(int'($urandom_range(0, 5)));
      launch(gl, 1'b0, m);
      finish_window($sformatf("rnd%0d", i), gl, m, ($urandom_range(0, 3) == 0), n);
      if ($urandom_range(0, 1) == 1) ack_check($sformatf("rnd%0d_ack", i), n);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
